// File: rtl/uart_tx_arbiter_if.sv
// Bus between the requesters/UART transmitter and the uart_tx_arbiter.
// master: requester and transmitter side; slave: the arbiter.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   gnt;
   logic [NUM_REQ-1:0]   ack;
   logic                 send_en;
   logic [7:0]           data_byte;
   logic                 tx_done;
   logic                 busy;
   logic                 err;

   modport master (
      output req, req_data, tx_done,
      input  gnt, ack, send_en, data_byte, busy, err
   );

   modport slave (
      input  req, req_data, tx_done,
      output gnt, ack, send_en, data_byte, busy, err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter logic [19:0] TIMEOUT = 20'd600000
) (
   input logic              clk,
   input logic              rst,
   uart_tx_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_DONE
   } state_t;

   // Elaboration-time guard against illegal configurations
   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 20'd2) begin : g_cfg_check
      $error("uart_tx_arbiter: illegal NUM_REQ or TIMEOUT");
   end

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IDX_W-1:0]     r_win;
   logic [IDX_W-1:0]     w_win_nxt;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     w_ptr_nxt;
   logic [NUM_REQ-1:0]   r_gnt;
   logic [NUM_REQ-1:0]   w_gnt_nxt;
   logic [NUM_REQ-1:0]   r_ack;
   logic [NUM_REQ-1:0]   w_ack_nxt;
   logic                 r_send;
   logic                 w_send_nxt;
   logic [7:0]           r_data;
   logic [7:0]           w_data_nxt;
   logic                 r_busy;
   logic                 r_err;
   logic                 w_err_nxt;
   logic                 w_found;
   logic [IDX_W-1:0]     w_sel;
   logic [7:0]           w_sel_data;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Index k positions after base, wrapping modulo NUM_REQ
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned     k);
      int unsigned s;
      s = 32'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IDX_W'(s);
   endfunction

   // First asserted request at or after the round-robin pointer
   always_comb begin
      w_found = 1'b0;
      w_sel   = r_ptr;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (!w_found && bus.req[rr_idx(r_ptr, k)]) begin
            w_found = 1'b1;
            w_sel   = rr_idx(r_ptr, k);
         end
      end
   end

   assign w_sel_data = bus.req_data[{w_sel, 3'b000} +: 8];

`ifdef UART_ARB_TIMEOUT_EN
   logic [19:0] r_cnt;

   // Watchdog: zero outside WAIT, counts WAIT cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_cnt <= r_cnt + 20'd1;
      end else begin
         r_cnt <= '0;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_win_nxt   = r_win;
      w_ptr_nxt   = r_ptr;
      w_gnt_nxt   = r_gnt;
      w_ack_nxt   = '0;
      w_send_nxt  = 1'b0;
      w_data_nxt  = r_data;
      w_err_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_LOAD;
               w_win_nxt   = w_sel;
               w_gnt_nxt   = onehot(w_sel);
               w_data_nxt  = w_sel_data;
               w_send_nxt  = 1'b1;
            end
         end
         S_LOAD: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // tx_done takes priority over a simultaneous watchdog expiry
            if (bus.tx_done) begin
               w_state_nxt = S_DONE;
               w_ack_nxt   = onehot(r_win);
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (r_cnt == TIMEOUT - 20'd1) begin
               w_state_nxt = S_DONE;
               w_ack_nxt   = onehot(r_win);
               w_err_nxt   = 1'b1;
            end
`endif
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
            w_ptr_nxt   = (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + IDX_W'(1);
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_win   <= '0;
         r_ptr   <= '0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_send  <= 1'b0;
         r_data  <= 8'h00;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_win   <= w_win_nxt;
         r_ptr   <= w_ptr_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ack   <= w_ack_nxt;
         r_send  <= w_send_nxt;
         r_data  <= w_data_nxt;
         r_busy  <= (w_state_nxt != S_IDLE);
         r_err   <= w_err_nxt;
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.ack       = r_ack;
   assign bus.send_en   = r_send;
   assign bus.data_byte = r_data;
   assign bus.busy      = r_busy;
   assign bus.err       = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter; inputs driven and outputs
// sampled on the falling clock edge.
module tb_uart_tx_arbiter;

   localparam int unsigned N = 4;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   n_send = 0;
   int   n_done = 0;
   exp_t sb[$];

   uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ(N),
      .TIMEOUT(20'd100)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (bus.send_en === 1'b1) n_send++;
   always @(posedge clk) if (bus.tx_done === 1'b1 && rst === 1'b0) n_done++;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [7:0] d);
      bus.req[i]              = 1'b1;
      bus.req_data[8*i +: 8]  = d;
   endtask

   task automatic push(input int i, input logic [7:0] d);
      exp_t e;
      e.idx  = i;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Wait (bounded) for send_en and compare against the scoreboard head
   task automatic wait_send(input string tag, output int idx, output int cyc);
      exp_t e;
      e.idx  = 0;
      e.data = 8'h00;
      cyc    = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.send_en !== 1'b1 && cyc < 40);
      check({tag, " send_en"}, 32'(bus.send_en), 32'd1);
      if (sb.size() != 0) e = sb.pop_front();
      idx = e.idx;
      check({tag, " gnt"}, 32'(bus.gnt), 32'd1 << e.idx);
      check({tag, " data_byte"}, 32'(bus.data_byte), 32'(e.data));
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
   endtask

   // Hold in WAIT, pulse tx_done, check the ack cycle and the return to idle
   task automatic finish_xfer(input string tag, input int idx, input int hold, input bit drop);
      repeat (hold) begin
         @(negedge clk);
         check({tag, " wait ack"}, 32'(bus.ack), 32'd0);
         check({tag, " wait send_en"}, 32'(bus.send_en), 32'd0);
      end
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      check({tag, " ack"}, 32'(bus.ack), 32'd1 << idx);
      check({tag, " gnt in done"}, 32'(bus.gnt), 32'd1 << idx);
      check({tag, " err"}, 32'(bus.err), 32'd0);
      if (drop) bus.req[idx] = 1'b0;
      @(negedge clk);
      check({tag, " ack clear"}, 32'(bus.ack), 32'd0);
      check({tag, " gnt clear"}, 32'(bus.gnt), 32'd0);
      check({tag, " busy clear"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int idx;
      int cyc;
      int s0;
      int d0;
      int bad;

      rst          = 1'b1;
      bus.req      = '0;
      bus.req_data = '0;
      bus.tx_done  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst gnt", 32'(bus.gnt), 32'd0);
      check("rst ack", 32'(bus.ack), 32'd0);
      check("rst send_en", 32'(bus.send_en), 32'd0);
      check("rst data_byte", 32'(bus.data_byte), 32'h00);
      check("rst busy", 32'(bus.busy), 32'd0);
      check("rst err", 32'(bus.err), 32'd0);
      rst = 1'b0;

      // tx_done while idle is ignored
      @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      check("idle tx_done ack", 32'(bus.ack), 32'd0);
      check("idle tx_done busy", 32'(bus.busy), 32'd0);

      // Single request, one-cycle latency; tx_done during LOAD ignored
      set_req(0, 8'h55);
      push(0, 8'h55);
      wait_send("t1", idx, cyc);
      check("t1 latency", 32'(cyc), 32'd1);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      check("t1 load tx_done ack", 32'(bus.ack), 32'd0);
      check("t1 load tx_done busy", 32'(bus.busy), 32'd1);
      finish_xfer("t1", idx, 2, 1'b1);

      // All four at once from ptr 0
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_req(i, 8'hA0 + 8'(i));
         push(i, 8'hA0 + 8'(i));
      end
      s0 = n_send;
      d0 = n_done;
      for (int i = 0; i < 4; i++) begin
         wait_send("t2", idx, cyc);
         finish_xfer("t2", idx, 3, 1'b1);
      end
      check("t2 send count", 32'(n_send - s0), 32'd4);
      check("t2 done count", 32'(n_done - d0), 32'd4);

      // Fairness: requester 0 held continuously alongside requester 2
      do_reset();
      set_req(0, 8'h10);
      set_req(2, 8'h20);
      push(0, 8'h10);
      push(2, 8'h20);
      push(0, 8'h10);
      push(2, 8'h20);
      for (int i = 0; i < 4; i++) begin
         wait_send("t3", idx, cyc);
         finish_xfer("t3", idx, 2, 1'b0);
      end
      bus.req = '0;

      // Reset during WAIT abandons the transfer; re-arbitration starts at ptr 0
      set_req(2, 8'h5A);
      push(2, 8'h5A);
      wait_send("t4 pre", idx, cyc);
      repeat (2) @(negedge clk);
      set_req(3, 8'h7B);
      @(negedge clk);
      check("t4 late req no effect", 32'(bus.gnt), 32'h4);
      rst = 1'b1;
      #1;
      check("t4 rst gnt", 32'(bus.gnt), 32'd0);
      check("t4 rst busy", 32'(bus.busy), 32'd0);
      check("t4 rst send_en", 32'(bus.send_en), 32'd0);
      check("t4 rst ack", 32'(bus.ack), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      push(2, 8'h5A);
      push(3, 8'h7B);
      wait_send("t4 a", idx, cyc);
      finish_xfer("t4 a", idx, 2, 1'b1);
      wait_send("t4 b", idx, cyc);
      finish_xfer("t4 b", idx, 2, 1'b1);

`ifdef UART_ARB_TIMEOUT_EN
      // Watchdog expiry: ack and err together 100 cycles after entering WAIT
      set_req(1, 8'hC3);
      push(1, 8'hC3);
      wait_send("t5", idx, cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bus.ack === 4'b0000 && cyc < 200);
      check("t5 timeout latency", 32'(cyc), 32'd101);
      check("t5 timeout ack", 32'(bus.ack), 32'h2);
      check("t5 timeout err", 32'(bus.err), 32'd1);
      bus.req[1] = 1'b0;
      @(negedge clk);
      check("t5 err clear", 32'(bus.err), 32'd0);
      check("t5 busy clear", 32'(bus.busy), 32'd0);

      // tx_done on the limit cycle wins over the watchdog
      set_req(1, 8'h3C);
      push(1, 8'h3C);
      wait_send("t6", idx, cyc);
      repeat (100) @(negedge clk);
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
      check("t6 ack", 32'(bus.ack), 32'h2);
      check("t6 err", 32'(bus.err), 32'd0);
      bus.req[1] = 1'b0;
      @(negedge clk);
      check("t6 busy clear", 32'(bus.busy), 32'd0);
`else
      // Without the watchdog WAIT never expires
      set_req(1, 8'hC3);
      push(1, 8'hC3);
      wait_send("t5", idx, cyc);
      bad = 0;
      repeat (150) begin
         @(negedge clk);
         if (bus.busy !== 1'b1 || bus.err !== 1'b0 || bus.ack !== 4'b0000) bad++;
      end
      check("t5 no timeout", 32'(bad), 32'd0);
      finish_xfer("t5", idx, 1, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART byte transmitter between several on-chip requesters. Each requester presents a byte with a level request; the arbiter picks one fairly, loads the byte into the transmitter with a one-cycle `send_en` pulse, waits for the transmitter's `tx_done`, then acknowledges the winner. Sits between the application logic (command responders, status reporters, debug streams) and the UART TX datapath.

## Interface
- `NUM_REQ`, 4: number of requesters, legal 2..8.
- `TIMEOUT`, 20'd600000: WAIT-state watchdog limit in clk cycles. Used only with the timeout feature; must exceed one 11-bit frame at the slowest baud.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NUM_REQ  level request per requester.
- `req_data`  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- `gnt`  out  NUM_REQ  one-hot, high while that requester's byte is in flight.
- `ack`  out  NUM_REQ  one-hot one-cycle pulse when that requester's byte has completed.
- `send_en`  out  1  one-cycle load strobe to transmitter.
- `data_byte`  out  8  byte to transmitter, stable from `send_en` until `ack`.
- `tx_done`  in  1  transmitter frame-complete pulse.
- `busy`  out  1  high whenever the FSM is not IDLE.
- `err`  out  1  timeout abort pulse; constant 0 without the timeout feature.

## Operation
- Requester rule: raise `req[i]` with `req_data[i]` valid; hold both stable until `ack[i]`; drop or update next cycle. Requests are never withdrawn before `ack`.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE: if any `req` high, select the winner as the first asserted index at or after round-robin pointer `ptr` (wrapping modulo NUM_REQ). Register winner index, `gnt`, and `data_byte`. Go to LOAD. Otherwise stay.
- LOAD: `send_en`=1 for exactly this cycle. Go to WAIT.
- WAIT: on `tx_done`=1 go to DONE. `tx_done` in IDLE or LOAD is ignored.
- DONE: `ack[winner]`=1 for this cycle. `ptr` <= winner+1, wrapping to 0 after NUM_REQ-1. Go to IDLE.
- A requester that keeps `req` high after its `ack` is re-eligible, but is ordered after all others because `ptr` has passed it.
- `req` changes outside IDLE have no effect on the current transfer.

## Timing
- Reset values: state IDLE, `ptr`=0, `gnt`=0, `ack`=0, `send_en`=0, `data_byte`=8'h00, `busy`=0, `err`=0.
- Reset mid-transfer: everything returns immediately to reset values. The transfer is abandoned without `ack`. The requester keeps `req` high and is re-arbitrated from `ptr`=0.
- `req` sampled high in IDLE cycle t: `gnt` and `data_byte` valid and `send_en`=1 in cycle t+1; WAIT from t+2.
- `tx_done` high in cycle d: `ack` in cycle d+1 (DONE); `gnt` and `busy` low in cycle d+2; the next arbitration is sampled in d+2.
- Minimum arbiter overhead per byte is 3 cycles plus transmitter frame time.
- `gnt` is high from the LOAD cycle through the DONE cycle inclusive.

## Configuration
- Macro `UART_ARB_TIMEOUT_EN`.
- Defined:
  - A 20-bit counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT-1 without `tx_done`, the FSM goes to DONE and `err`=1 together with `ack[winner]` for one cycle. `ptr` advances as normal.
  - If `tx_done` arrives in the same cycle the limit is reached, `tx_done` wins and `err` stays 0.
- Undefined: no counter; WAIT waits indefinitely; `err` is tied to 0.

## Test plan
- Single request: `req`=0001, byte 8'h55. Required: `send_en` pulse 1 cycle later with `data_byte`=8'h55 and `gnt`=0001. `tx_done` pulse gives `ack`=0001 next cycle, then `busy`=0.
- All four requesters, bytes A0..A3 simultaneously, `ptr`=0. Required: `send_en` order A0, A1, A2, A3; each `ack` exactly once; exactly one `send_en` per `tx_done`.
- Fairness: `req[0]` held continuously with `req[2]`. Required: grant order 0, 2, 0, 2; never two consecutive grants to 0 while 2 pending.
- Reset asserted in WAIT. Required: `gnt`, `busy`, `send_en`, `ack` all 0 immediately. After release with `req`=0100 still high, requester 2 is re-served first.
- With `UART_ARB_TIMEOUT_EN`, TIMEOUT=100, `tx_done` never pulses. Required: `ack` and `err` pulse together 100 cycles after entering WAIT. Without the macro: `busy` stays 1 and `err`=0.
- With the macro, `tx_done` coincides with the counter reaching 99. Required: `ack` pulse, `err`=0.
